// File: rtl/mp_adder_arbiter_if.sv
// mp_adder_arbiter_if: client request/response bundle plus the adder-facing start/operand/result signals.
interface mp_adder_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int OPERAND_WIDTH = 128
);
   logic [NUM_REQ-1:0] iReqValid, oReqReady, oRspValid, iRspReady;
   logic [NUM_REQ*OPERAND_WIDTH-1:0] iReqOpA, iReqOpB;
   logic [OPERAND_WIDTH:0] oRspRes, iAddRes;
   logic [OPERAND_WIDTH-1:0] oAddOpA, oAddOpB;
   logic oRspErr, oAddStart, iAddDone, oBusy;
   modport slave (
      input iReqValid, iReqOpA, iReqOpB, iRspReady, iAddRes, iAddDone,
      output oReqReady, oRspValid, oRspRes, oRspErr, oAddStart, oAddOpA, oAddOpB, oBusy
   );
   modport master (
      output iReqValid, iReqOpA, iReqOpB, iRspReady, iAddRes, iAddDone,
      input oReqReady, oRspValid, oRspRes, oRspErr, oAddStart, oAddOpA, oAddOpB, oBusy
   );
endinterface

// File: rtl/mp_adder_arbiter.sv
// mp_adder_arbiter: round-robin sharing of one mp_adder among NUM_REQ clients, with a done watchdog.
module mp_adder_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int OPERAND_WIDTH = 128,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic iClk,
   input logic iRst,
   mp_adder_arbiter_if.slave bus
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} stateT;
   stateT state;
   logic [GW-1:0] g, ptr, grant;
   logic found, err, timeout;
   logic [CW-1:0] cnt;
   logic [OPERAND_WIDTH:0] res;
   logic [OPERAND_WIDTH-1:0] opA, opB;
   // descending scan so the lowest offset from ptr wins
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (bus.iReqValid[(int'(ptr) + k) % NUM_REQ]) begin
            grant = GW'((int'(ptr) + k) % NUM_REQ);
            found = 1'b1;
         end
   end
   assign timeout = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
   assign bus.oReqReady = (!iRst && state == IDLE && found) ? NUM_REQ'(1) << grant : '0;
   assign bus.oRspValid = state == RESP ? NUM_REQ'(1) << g : '0;
   assign bus.oRspRes = res;
   assign bus.oRspErr = err;
   assign bus.oAddStart = state == START;
   assign bus.oAddOpA = opA;
   assign bus.oAddOpB = opB;
   assign bus.oBusy = state != IDLE;
   always_ff @(posedge iClk or posedge iRst)
      if (iRst) begin
         state <= IDLE;
         g <= '0;
         ptr <= '0;
         opA <= '0;
         opB <= '0;
         res <= '0;
         err <= 1'b0;
         cnt <= '0;
      end else
         case (state)
            IDLE:
               if (found) begin
                  opA <= bus.iReqOpA[int'(grant)*OPERAND_WIDTH +: OPERAND_WIDTH];
                  opB <= bus.iReqOpB[int'(grant)*OPERAND_WIDTH +: OPERAND_WIDTH];
                  g <= grant;
                  err <= 1'b0;
                  state <= START;
               end
            START: begin
               cnt <= '0;
               state <= WAIT;
            end
            WAIT:
               if (bus.iAddDone) begin
                  res <= bus.iAddRes;
                  err <= 1'b0;
                  state <= RESP;
               end else if (timeout) begin
                  res <= '0;
                  err <= 1'b1;
                  state <= RESP;
               end else
                  cnt <= cnt + 1'b1;
            RESP:
               if (bus.iRspReady[g]) begin
                  ptr <= (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
endmodule

// File: doc/mp_adder_arbiter.md
# mp_adder_arbiter

Round-robin arbiter and sequencer that shares one `mp_adder` instance among `NUM_REQ` requesters. It accepts operand pairs over a valid/ready handshake and drives the adder's start/operand inputs. It captures the adder result on done and returns it to the granted requester over a second valid/ready handshake. A watchdog aborts a transaction whose done never arrives. It sits between client blocks and the adder; the adder is wired directly to the `oAdd*`/`iAdd*` ports.

## Interface

Parameters:
- `NUM_REQ`, 4, number of requesters (2..8).
- `OPERAND_WIDTH`, 128, operand width; must match the adder.
- `TIMEOUT_CYCLES`, 64, maximum cycles spent in WAIT before abort; 0 disables the watchdog.

Ports:
- `iClk`  in  1  clock; everything is rising-edge.
- `iRst`  in  1  reset, asynchronous, active-high; shared with the adder.
- `iReqValid`  in  NUM_REQ  per-requester request valid.
- `iReqOpA`  in  NUM_REQ*OPERAND_WIDTH  flattened operand A; requester i occupies slice [i*W +: W].
- `iReqOpB`  in  NUM_REQ*OPERAND_WIDTH  flattened operand B, same packing.
- `oReqReady`  out  NUM_REQ  one-hot accept strobe.
- `oRspValid`  out  NUM_REQ  one-hot response valid.
- `oRspRes`  out  OPERAND_WIDTH+1  sum including carry-out.
- `oRspErr`  out  1  response is a timeout abort; qualified by `oRspValid`.
- `iRspReady`  in  NUM_REQ  per-requester response ready.
- `oAddStart`  out  1  start pulse to adder `iStart`.
- `oAddOpA`, `oAddOpB`  out  OPERAND_WIDTH each  held operands to the adder.
- `iAddRes`  in  OPERAND_WIDTH+1  adder `oRes`.
- `iAddDone`  in  1  adder `oDone`.
- `oBusy`  out  1  high in every state except IDLE.

## Operation

- FSM states: IDLE, START, WAIT, RESP. The registers are the state, grant index `g`, priority pointer `ptr`, operand registers, result register, error flag and watchdog counter.
- IDLE:
  - Grant goes to the first requester with `iReqValid` set, scanning from `ptr` upward modulo NUM_REQ.
  - `oReqReady[g]` is combinational and asserted only in IDLE, only for the granted requester.
  - On the edge where valid and ready are both high, capture `iReqOpA`/`iReqOpB` slice `g` into `oAddOpA`/`oAddOpB`, latch `g`, clear the error flag, and go to START.
- START: `oAddStart`=1 for exactly this one cycle. Clear the watchdog counter. Go to WAIT.
- WAIT:
  - If `iAddDone`=1, latch `iAddRes` into `oRspRes`, set err=0 and go to RESP.
  - Otherwise, if TIMEOUT_CYCLES≠0 and the counter has reached TIMEOUT_CYCLES−1, set `oRspRes`=0, set err=1 and go to RESP.
  - Otherwise increment the counter.
  - If done and timeout coincide, done wins.
- RESP:
  - `oRspValid[g]`=1 and `oRspErr` shows the error flag.
  - When `iRspReady[g]`=1, set `ptr`=(g+1) mod NUM_REQ and go to IDLE.
  - `iRspReady` of non-granted requesters is ignored.
- `oAddOpA`/`oAddOpB` hold their values from capture until the next capture and are not cleared between transactions.
- `iAddDone` is ignored outside WAIT, whether it is a stale level or a late done after a timeout.
- Requesters hold valid and operands stable until accepted. Deasserting valid before accept withdraws the request without error.
- Arithmetic is performed entirely by the adder; the arbiter never modifies operands or results.

## Timing

- Reset values: state=IDLE, ptr=0, `oReqReady`=0 (forced low while `iRst`=1), `oRspValid`=0, `oRspRes`=0, `oRspErr`=0, `oAddStart`=0, `oAddOpA`=`oAddOpB`=0, `oBusy`=0.
- Accept on edge t → `oAddStart` high in cycle t+1 → WAIT from t+2.
- `iAddDone` sampled high at edge d → `oRspValid` high from cycle d+1.
- A response handshake at edge r allows a new accept at edge r+1 at the earliest.
- Per-transaction overhead is adder latency + 3 cycles.
- Timeout: a transaction with no done has `oRspValid` asserted exactly TIMEOUT_CYCLES+2 cycles after the accept edge.
- Reset mid-operation returns to IDLE immediately, discards the transaction, and sends no response.

## Test plan

- **Single request:** requester 1 sends A=0x12121212_34343434_56565656_78787878 and B=0xefefefef_cdcdcdcd_abababab_90909090 → `oRspValid`=4'b0010, `oRspRes`=0x1_02020202_02020202_02020202_09090908, `oRspErr`=0; `oAddStart` pulses exactly once.
- **Round robin:** all four valid continuously from reset with distinct operands → grant order 0,1,2,3,0; each result equals the sum of that requester's own operands.
- **Pointer skip:** only requesters 0 and 2 valid after requester 0 is served → requester 2 is granted next, then 0.
- **Backpressure:** hold `iRspReady[g]`=0 for 10 cycles → `oRspValid` and `oRspRes` stay stable, no new accept, `oBusy`=1; release → IDLE next cycle.
- **Timeout:** stub `iAddDone`=0 with TIMEOUT_CYCLES=8 → response at accept+10 cycles with `oRspErr`=1 and `oRspRes`=0; a late `iAddDone` is ignored.
- **Reset mid-WAIT:** assert `iRst` for 1 cycle during WAIT → all outputs return to reset values asynchronously, no response is issued, and the next request (ptr=0) is served correctly.
